// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// latency counter width and the store strobe-to-byte-lane mapping.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LANE_W = 8;

  // Strobe bit i enables byte lane i (bits 8i+7:8i); same mapping as the core's store aligner.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[i*LANE_W +: LANE_W] = {LANE_W{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_byte_en_ram.sv
// Word-organised RAM with a byte-masked synchronous write and a registered
// read, both on the same edge. Contents start at zero and are never reset.
module dmem_responder_byte_en_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic [31:0]   rdata
);
  import dmem_responder_pkg::*;

  logic [31:0] mem [DEPTH] = '{default: 32'h0};
  logic [31:0] mask;

  assign mask = strb_to_mask(wstrb);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed access latency,
// address range/alignment checking and a byte-enabled backing RAM.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// BUSY  | request captured; latency counter running down, access at zero
// RESP  | response presented until the initiator takes it
module dmem_responder #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);
  import dmem_responder_pkg::*;

  localparam int unsigned     AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              cap_write;
  logic              cap_err;
  logic [AW-1:0]     cap_idx;
  logic [31:0]       cap_wdata;
  logic [3:0]        cap_wstrb;

  logic [31:0]       offset;
  logic              addr_err;
  logic              accept;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  // Subtraction wraps, so addresses below START_ADDR land far out of range.
  assign offset   = bus.req_addr - START_ADDR;
  assign addr_err = (offset[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= 32'(MEM_DEPTH));

  assign bus.req_ready = (state == ST_IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= bus.req_write;
      cap_err   <= addr_err;
      cap_idx   <= offset[AW+1:2];
      cap_wdata <= bus.req_wdata;
      cap_wstrb <= bus.req_wstrb;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = LAT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ST_RESP;
          // A reset landing on the commit edge must drop the store.
          ram_we    = cap_write && !cap_err && !rst;
          ram_re    = !cap_write && !cap_err;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  dmem_responder_byte_en_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .wstrb (cap_wstrb),
    .rdata (ram_rdata)
  );

  // Response fields only carry data while in RESP, so leaving RESP clears them.
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_err   = bus.rsp_valid && cap_err;
  assign bus.rsp_rdata = (bus.rsp_valid && !cap_write && !cap_err) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for functional
// cases and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  dmem_responder #(
    .MEM_DEPTH  (256),
    .START_ADDR (32'h0000_0000),
    .LATENCY    (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  dmem_responder #(
    .MEM_DEPTH  (256),
    .START_ADDR (32'h0000_0000),
    .LATENCY    (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the LATENCY=2 instance with latency and response checks.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    int n;
    int lat;
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_wstrb = strb;
    bus0.req_valid = 1'b1;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req_ready"}, 32'(bus0.req_ready), 32'd1);
    step();
    bus0.req_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus0.rsp_valid && lat < 40);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, bus0.rsp_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(bus0.rsp_err), 32'(exp_err));
    bus0.rsp_ready = 1'b1;
    step();
    bus0.rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, {bus0.rsp_rdata[30:0], bus0.rsp_valid}, 32'd0);
  endtask

  function automatic logic [31:0] b2b_exp(input int k);
    return (k < 10) ? 32'h0 : (32'hA500_0000 | 32'(k - 10));
  endfunction

  task automatic set_req1(input int i);
    bus1.req_write = (i < 10);
    bus1.req_addr  = 32'((i % 10) * 4);
    bus1.req_wdata = 32'hA500_0000 | 32'(i);
    bus1.req_wstrb = 4'hF;
  endtask

  initial begin
    int n;
    int cyc;
    int idx;
    int nrsp;
    int last_acc;
    logic        ready_now;
    logic        valid_now;
    logic        err_now;
    logic [31:0] rd_now;

    rst = 1'b1;
    {bus0.req_valid, bus0.req_write, bus0.req_addr, bus0.req_wdata, bus0.req_wstrb, bus0.rsp_ready} = '0;
    {bus1.req_valid, bus1.req_write, bus1.req_addr, bus1.req_wdata, bus1.req_wstrb} = '0;
    bus1.rsp_ready = 1'b1;

    step();
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("post_rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
    chk("post_rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
    chk("post_rst_req_ready", 32'(bus0.req_ready), 32'd1);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "st_full");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "ld_full");
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, "st_byte0");
    txn(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 32'hDEADBEAA, 1'b0, "ld_byte0");
    txn(1'b1, 32'h10, 32'h11223344, 4'b0110, 32'h0, 1'b0, "st_mid");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE2233AA, 1'b0, "ld_mid");
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "st_nostrb");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE2233AA, 1'b0, "ld_nostrb");
    txn(1'b1, 32'h10, 32'hDEADBEAA, 4'hF, 32'h0, 1'b0, "st_restore");

    txn(1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, "ld_misalign");
    txn(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, "ld_range");
    txn(1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0, 1'b1, "st_range");
    txn(1'b1, 32'h11, 32'h66666666, 4'hF, 32'h0, 1'b1, "st_misalign");
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, "ld_wrap");
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, "ld_word0");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "ld_after_err");
    txn(1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, "st_last");
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, "ld_last");

    // Response stall with a competing request held on the bus.
    bus0.req_write = 1'b0;
    bus0.req_addr  = 32'h10;
    bus0.req_valid = 1'b1;
    step();
    bus0.req_addr = 32'h3FC;
    n = 0;
    while (!bus0.rsp_valid && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", bus0.rsp_rdata, 32'hDEADBEAA);
      chk("hold_rsp_err", 32'(bus0.rsp_err), 32'd0);
      chk("hold_req_ready", 32'(bus0.req_ready), 32'd0);
      step();
    end
    bus0.rsp_ready = 1'b1;
    step();
    bus0.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0;
    chk("hold_release_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("hold_release_req_ready", 32'(bus0.req_ready), 32'd1);

    // Reset on the commit edge of a store.
    bus0.req_write = 1'b1;
    bus0.req_addr  = 32'h20;
    bus0.req_wdata = 32'h12345678;
    bus0.req_wstrb = 4'hF;
    bus0.req_valid = 1'b1;
    step();
    bus0.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("busy_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("busy_rst_req_ready", 32'(bus0.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("busy_rst_after_req_ready", 32'(bus0.req_ready), 32'd1);
    chk("busy_rst_after_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, "ld_dropped");

    // Reset while a committed store's response is pending.
    bus0.req_write = 1'b1;
    bus0.req_addr  = 32'h24;
    bus0.req_wdata = 32'hCAFEF00D;
    bus0.req_wstrb = 4'hF;
    bus0.req_valid = 1'b1;
    step();
    bus0.req_valid = 1'b0;
    n = 0;
    while (!bus0.rsp_valid && n < 40) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("resp_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    txn(1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "ld_committed");

    // Back-to-back on the LATENCY=1 instance with rsp_ready tied high.
    idx      = 0;
    nrsp     = 0;
    cyc      = 0;
    last_acc = 0;
    set_req1(0);
    bus1.req_valid = 1'b1;
    while ((idx < 20 || nrsp < 20) && cyc < 200) begin
      ready_now = bus1.req_ready;
      valid_now = bus1.rsp_valid;
      rd_now    = bus1.rsp_rdata;
      err_now   = bus1.rsp_err;
      step();
      cyc++;
      if (valid_now) begin
        chk("b2b_rdata", rd_now, b2b_exp(nrsp));
        chk("b2b_err", 32'(err_now), 32'd0);
        nrsp++;
      end
      if (ready_now && idx < 20) begin
        if (idx > 0) chk("b2b_period", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        idx++;
        if (idx < 20) set_req1(idx);
        else bus1.req_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 32'(idx), 32'd20);
    chk("b2b_responses", 32'(nrsp), 32'd20);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus1.rsp_valid) n++;
      step();
    end
    chk("b2b_no_extra_rsp", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
